// File: rtl/ysyx_22040125_pc_gen.sv
// ---------------------------------------------------------------------------
// ysyx_22040125_pc_gen
// Fetch program-counter generator with a small circular return-address stack.
//
// Next-PC priority: trap > redirect > hold (no accept) > ret > call > pc+ILEN.
// A fetch is accepted ("acc") when pc_valid && fetch_ready && !stall.
//
// Ports
//   clk            in   clock
//   rst            in   synchronous, active-low reset
//   stall          in   hold PC
//   fetch_ready    in   fetch stage accepts cpu_pc this cycle
//   redirect_valid in   misprediction resolved, load redirect_pc
//   redirect_pc    in   corrected target (XLEN)
//   trap_valid     in   trap/exception/mret entry, load trap_pc, flush RAS
//   trap_pc        in   trap target (XLEN)
//   call           in   instruction at cpu_pc predicted as call
//   call_target    in   predicted call target (XLEN)
//   ret            in   instruction at cpu_pc predicted as return
//   pc_valid       out  cpu_pc is a valid fetch address
//   cpu_pc         out  current fetch PC (XLEN)
//   ras_count      out  occupied RAS entries
//   ras_underflow  out  one-cycle pulse: accepted ret with empty RAS
// ---------------------------------------------------------------------------
module ysyx_22040125_pc_gen #(
   parameter int              XLEN      = 64,
   parameter logic [XLEN-1:0] RESET_VEC = 'h80000000,
   parameter int              ILEN      = 4,
   parameter int              RAS_DEPTH = 4,
   localparam int             CW        = $clog2(RAS_DEPTH + 1),
   localparam int             PW        = $clog2(RAS_DEPTH)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            fetch_ready,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            trap_valid,
   input  logic [XLEN-1:0] trap_pc,
   input  logic            call,
   input  logic [XLEN-1:0] call_target,
   input  logic            ret,
   output logic            pc_valid,
   output logic [XLEN-1:0] cpu_pc,
   output logic [CW-1:0]   ras_count,
   output logic            ras_underflow
);

   localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
   localparam logic [CW-1:0]   CNT_FULL   = CW'(RAS_DEPTH);

   logic [XLEN-1:0] r_pc;
   logic            r_pc_valid;
   logic [CW-1:0]   r_count;
   logic [PW-1:0]   r_top;       // index of the most recently pushed entry
   logic            r_uflow;
   logic [XLEN-1:0] r_ras [RAS_DEPTH];

   logic            w_acc;
   logic [XLEN-1:0] w_seq;
   logic [XLEN-1:0] w_top_entry;
   logic [XLEN-1:0] w_pc_next;
   logic [CW-1:0]   w_count_next;
   logic [PW-1:0]   w_top_next;
   logic            w_uflow_next;
   logic            w_wr_en;
   logic [PW-1:0]   w_wr_idx;

   assign w_acc       = r_pc_valid && fetch_ready && !stall;
   assign w_seq       = r_pc + XLEN'(ILEN);   // wraps modulo 2^XLEN
   // Small stack kept in registers: the popped entry must steer the very
   // next PC, so it is read combinationally.
   assign w_top_entry = r_ras[r_top];

   always_comb begin
      w_pc_next    = r_pc;
      w_count_next = r_count;
      w_top_next   = r_top;
      w_uflow_next = 1'b0;
      w_wr_en      = 1'b0;
      w_wr_idx     = r_top;

      if (trap_valid) begin
         w_pc_next    = trap_pc & ALIGN_MASK;
         w_count_next = '0;
      end else if (redirect_valid) begin
         w_pc_next = redirect_pc & ALIGN_MASK;
      end else if (w_acc) begin
         if (ret && (r_count == '0)) begin
            // Empty stack: fall through sequentially, but a same-cycle
            // call still records its link.
            w_pc_next    = w_seq;
            w_uflow_next = 1'b1;
            if (call) begin
               w_wr_en      = 1'b1;
               w_wr_idx     = r_top + PW'(1);
               w_top_next   = r_top + PW'(1);
               w_count_next = r_count + CW'(1);
            end
         end else if (ret && call) begin
            // Return-then-call: consume the top and replace it in place.
            w_pc_next = w_top_entry;
            w_wr_en   = 1'b1;
            w_wr_idx  = r_top;
         end else if (ret) begin
            w_pc_next    = w_top_entry;
            w_top_next   = r_top - PW'(1);
            w_count_next = r_count - CW'(1);
         end else if (call) begin
            // Circular push: when full, this overwrites the oldest entry.
            w_pc_next  = call_target & ALIGN_MASK;
            w_wr_en    = 1'b1;
            w_wr_idx   = r_top + PW'(1);
            w_top_next = r_top + PW'(1);
            if (r_count != CNT_FULL) begin
               w_count_next = r_count + CW'(1);
            end
         end else begin
            w_pc_next = w_seq;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_pc       <= RESET_VEC;
         r_pc_valid <= 1'b0;
         r_count    <= '0;
         r_top      <= '0;
         r_uflow    <= 1'b0;
      end else begin
         r_pc       <= w_pc_next;
         r_pc_valid <= 1'b1;
         r_count    <= w_count_next;
         r_top      <= w_top_next;
         r_uflow    <= w_uflow_next;
      end
   end

   // Entry storage is not reset; ras_count alone decides what is live.
   always_ff @(posedge clk) begin
      if (rst && w_wr_en) begin
         r_ras[w_wr_idx] <= w_seq;
      end
   end

   assign pc_valid      = r_pc_valid;
   assign cpu_pc        = r_pc;
   assign ras_count     = r_count;
   assign ras_underflow = r_uflow;

endmodule

// File: doc/ysyx_22040125_pc_gen.md
YSYX_22040125_PC_GEN -- requirements
Module: ysyx_22040125_pc_gen

Interface
REQ-001 Parameters (name, default, meaning), SHALL be:
- XLEN, 64, address width
- RESET_VEC, 64'h80000000, PC after reset
- ILEN, 4, sequential increment in bytes
- RAS_DEPTH, 4, return-address-stack entries; power of 2, >= 2
REQ-002 Ports (name direction width meaning), SHALL be:
- clk in 1 clock
- rst in 1 reset, synchronous, active-low
- stall in 1 hold PC (pipeline stall)
- fetch_ready in 1 fetch stage accepts cpu_pc this cycle
- redirect_valid in 1 branch/jump misprediction resolved
- redirect_pc in XLEN corrected target
- trap_valid in 1 trap/exception/mret entry
- trap_pc in XLEN trap target (mtvec/mepc)
- call in 1 instruction at cpu_pc predicted as call
- call_target in XLEN predicted call target
- ret in 1 instruction at cpu_pc predicted as return
- pc_valid out 1 cpu_pc is a valid fetch address
- cpu_pc out XLEN current fetch PC
- ras_count out $clog2(RAS_DEPTH+1) occupied RAS entries
- ras_underflow out 1 one-cycle pulse: ret with empty RAS

Function
REQ-003 Accept event "acc" SHALL be pc_valid && fetch_ready && !stall.
REQ-004 Next-PC priority SHALL be: trap_valid > redirect_valid > !acc (hold) > ret > call > cpu_pc+ILEN.
REQ-005 trap_valid SHALL load cpu_pc <= trap_pc next cycle regardless of stall/fetch_ready, and SHALL clear ras_count to 0.
REQ-006 redirect_valid (no trap) SHALL load cpu_pc <= redirect_pc next cycle regardless of stall/fetch_ready; RAS unchanged.
REQ-007 Loaded trap_pc/redirect_pc/call_target SHALL have bits [1:0] forced to 0.
REQ-008 Without trap/redirect and !acc, cpu_pc and RAS SHALL hold; call/ret ignored.
REQ-009 acc && call && !ret: push cpu_pc+ILEN, cpu_pc <= call_target.
REQ-010 acc && ret && !call, ras_count>0: pop, cpu_pc <= popped entry, ras_count-1.
REQ-011 acc && ret, ras_count==0: cpu_pc <= cpu_pc+ILEN, ras_underflow=1 next cycle for exactly one cycle; a call in the same cycle SHALL still push.
REQ-012 acc && call && ret, ras_count>0: cpu_pc <= top entry; top overwritten with cpu_pc+ILEN; ras_count unchanged.
REQ-013 RAS SHALL be circular: push when ras_count==RAS_DEPTH overwrites oldest entry; ras_count saturates at RAS_DEPTH.
REQ-014 Sequential addition SHALL be modulo 2^XLEN (wrap, no flag).
REQ-015 pc_valid SHALL be 0 in reset and 1 from first cycle after rst release; combinational only on registered state.
REQ-016 All outputs SHALL be registered.

Reset
REQ-017 rst==0 at posedge clk SHALL set cpu_pc=RESET_VEC, pc_valid=0, ras_count=0, ras_underflow=0, overriding all inputs incl. trap_valid.
REQ-018 Reset mid-operation SHALL discard RAS contents; RAS entry storage need not be reset.

Verification
REQ-019 Reset then fetch_ready=1, stall=0 for 3 cycles -> cpu_pc 0x80000000, 0x80000004, 0x80000008; pc_valid 0 during reset, 1 after.
REQ-020 stall=1 with redirect_valid=1, redirect_pc=0x80001003 -> next cpu_pc=0x80001000; stall alone -> cpu_pc held.
REQ-021 At 0x80000010 call, call_target=0x80002000; later ret -> cpu_pc=0x80002000, then 0x80000014; ras_count 1 then 0.
REQ-022 5 nested calls with RAS_DEPTH=4 -> ras_count=4; 4 rets return 4 newest links; 5th ret -> cpu_pc+4, ras_underflow pulse.
REQ-023 trap_valid and redirect_valid same cycle, trap_pc=0x80000100 -> cpu_pc=0x80000100, ras_count=0.
REQ-024 cpu_pc=0xFFFFFFFFFFFFFFFC, acc -> cpu_pc=0x0.
